// File: rtl/inert_spi_pkg.sv
// inert_spi_pkg: register map and serf state encoding shared by the SPI serf model.
package inert_spi_pkg;
  localparam logic [6:0] INT1_CTRL = 7'h0D;
  localparam logic [6:0] WHO_AM_I  = 7'h0F;
  localparam logic [6:0] CTRL2_G   = 7'h11;
  localparam logic [6:0] CTRL5_C   = 7'h14;
  localparam logic [6:0] OUTZ_L    = 7'h26;
  localparam logic [6:0] OUTZ_H    = 7'h27;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} serf_state_e;
endpackage

// File: rtl/spi_serf_phy.sv
// spi_serf_phy: SPI mode 3 serf framing -- synchronisers, edge detect, shift registers,
// bit counter and the IDLE/SHIFT/COMMIT frame state machine.
module spi_serf_phy
  import inert_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic [7:0]  tx_byte,
  output logic        MISO,
  output logic        frame_done,
  output logic        tx_ld,
  output logic [15:0] rx
);
  logic [2:0] ss_q, ss_d, sclk_q, sclk_d;
  logic [1:0] mosi_q, mosi_d;
  serf_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic miso_q, miso_d, ld_q, ld_d;
  logic ss_fall, ss_rise, rise, fall;

  always_comb begin
    ss_d = {ss_q[1:0], SS_n};
    sclk_d = {sclk_q[1:0], SCLK};
    mosi_d = {mosi_q[0], MOSI};
    ss_fall = ss_q[2] & ~ss_q[1];
    ss_rise = ~ss_q[2] & ss_q[1];
    rise = ~sclk_q[2] & sclk_q[1] & ~ss_q[1];
    fall = sclk_q[2] & ~sclk_q[1] & ~ss_q[1];
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    miso_d = miso_q;
    ld_d = 1'b0;
    case (state_q)
      IDLE: if (ss_fall) begin
        state_d = SHIFT;
        cnt_d = '0;
        tx_d = '0;
        miso_d = 1'b0;
      end
      SHIFT: if (ss_rise) state_d = (cnt_q == 5'd16) ? COMMIT : IDLE;
      else begin
        if (rise) begin
          rx_d = {rx_q[14:0], mosi_q[1]};
          cnt_d = (cnt_q == 5'd16) ? cnt_q : cnt_q + 5'd1;
          ld_d = cnt_q == 5'd7;
        end
        if (ld_q) tx_d = tx_byte;
        else if (fall && cnt_q >= 5'd8 && cnt_q < 5'd16) begin
          miso_d = tx_q[7];
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // select chain resets low so a select held low across reset never looks like a new frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ss_q <= '0;
      sclk_q <= '1;
      mosi_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      miso_q <= 1'b0;
      ld_q <= 1'b0;
    end else begin
      ss_q <= ss_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      miso_q <= miso_d;
      ld_q <= ld_d;
    end

  assign MISO = miso_q;
  assign frame_done = state_q == COMMIT;
  assign tx_ld = ld_q;
  assign rx = rx_q;
endmodule

// File: rtl/inert_spi_serf.sv
// inert_spi_serf: SPI serf model of the 6-axis inertial sensor (register file, sample timer, drdy/lock).
// INERT_SERF_NOISE_EN adds LFSR noise (-8..+7, saturating) to every OUTZ load.
module inert_spi_serf
  import inert_spi_pkg::*;
#(
  parameter int          SMPL_PRD     = 120192,
  parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               INT,
  input  logic signed [15:0] yaw_in
);
  logic frame_done, tx_ld;
  logic [15:0] rx;
  logic [7:0] tx_byte, rd_byte;
  logic [6:0] addr, ra;
  logic [7:0] int1_q, int1_d, ctrl2_q, ctrl2_d, ctrl5_q, ctrl5_d;
  logic [15:0] outz_q, outz_d, load_val;
  logic [16:0] tmr_q, tmr_d;
  logic drdy_q, drdy_d, lock_q, lock_d, pend_q, pend_d, int_q, int_d;
  logic wr, rd, tick, unlock, clr, load;
`ifdef INERT_SERF_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [16:0] sum;
`endif

  spi_serf_phy u_phy (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .tx_byte(tx_byte),
    .MISO(MISO), .frame_done(frame_done), .tx_ld(tx_ld), .rx(rx)
  );

  always_comb begin
    addr = rx[14:8];
    ra = rx[6:0];
    wr = frame_done & ~rx[15];
    rd = frame_done & rx[15];
    tick = (ctrl2_q != 8'h00) && (tmr_q == 17'(SMPL_PRD - 1));
    unlock = rd && addr == OUTZ_L && lock_q;
    clr = rd && addr == OUTZ_H;
    load = (tick && !lock_q) || (unlock && (pend_q || tick));
    int1_d = (wr && addr == INT1_CTRL) ? rx[7:0] : int1_q;
    ctrl2_d = (wr && addr == CTRL2_G) ? rx[7:0] : ctrl2_q;
    ctrl5_d = (wr && addr == CTRL5_C) ? rx[7:0] : ctrl5_q;
    tmr_d = (wr && addr == CTRL2_G && rx[7:0] == 8'h00) ? '0 :
            (ctrl2_q == 8'h00) ? tmr_q : tick ? '0 : tmr_q + 17'd1;
    lock_d = clr ? 1'b1 : (rd && addr == OUTZ_L) ? 1'b0 : lock_q;
    pend_d = unlock ? 1'b0 : (tick && lock_q) ? 1'b1 : pend_q;
    drdy_d = (clr && (lock_q || !load)) ? 1'b0 : load ? 1'b1 : drdy_q;
`ifdef INERT_SERF_NOISE_EN
    lfsr_d = tick ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    sum = {yaw_in[15], yaw_in} + {{13{lfsr_q[3]}}, lfsr_q[3:0]};
    load_val = (sum[16] != sum[15]) ? {sum[16], {15{~sum[16]}}} : sum[15:0];
`else
    load_val = yaw_in;
`endif
    outz_d = load ? load_val : outz_q;
    int_d = drdy_q & int1_q[1];
    // read data is chosen from the address byte just shifted in, before the data byte
    rd_byte = (ra == INT1_CTRL) ? int1_q : (ra == WHO_AM_I) ? WHO_AM_I_VAL :
              (ra == CTRL2_G) ? ctrl2_q : (ra == CTRL5_C) ? ctrl5_q :
              (ra == OUTZ_L) ? outz_q[7:0] : (ra == OUTZ_H) ? outz_q[15:8] : 8'h00;
    tx_byte = tx_ld ? rd_byte : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      int1_q <= '0;
      ctrl2_q <= '0;
      ctrl5_q <= '0;
      outz_q <= '0;
      tmr_q <= '0;
      drdy_q <= 1'b0;
      lock_q <= 1'b0;
      pend_q <= 1'b0;
      int_q <= 1'b0;
`ifdef INERT_SERF_NOISE_EN
      lfsr_q <= 16'hACE1;
`endif
    end else begin
      int1_q <= int1_d;
      ctrl2_q <= ctrl2_d;
      ctrl5_q <= ctrl5_d;
      outz_q <= outz_d;
      tmr_q <= tmr_d;
      drdy_q <= drdy_d;
      lock_q <= lock_d;
      pend_q <= pend_d;
      int_q <= int_d;
`ifdef INERT_SERF_NOISE_EN
      lfsr_q <= lfsr_d;
`endif
    end

  assign INT = int_q;
endmodule

// File: tb/tb_inert_spi_serf.sv
// tb_inert_spi_serf: directed SPI frames against a transaction-level model of the sensor registers.
module tb_inert_spi_serf;
  localparam int PRD = 64;
  localparam int HALF = 8;
  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
  logic MISO, INT;
  logic [15:0] yaw_in = 16'h0000;
  int errs = 0, checks = 0, cyc = 0, t_ss = 0;
  logic [7:0] m_int1, m_ctrl2, m_ctrl5;
  logic [15:0] m_outz;
  logic m_drdy, m_lock, m_pend;
  logic [7:0] exp_rx;
  logic miso_chk = 1'b0, int_chk = 1'b0;
  int bit_i = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inert_spi_serf #(.SMPL_PRD(PRD)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT), .yaw_in(yaw_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    return a == 7'h0D ? m_int1 : a == 7'h0F ? 8'h6A : a == 7'h11 ? m_ctrl2 : a == 7'h14 ? m_ctrl5 :
           a == 7'h26 ? m_outz[7:0] : a == 7'h27 ? m_outz[15:8] : 8'h00;
  endfunction

  task automatic m_reset();
    m_int1 = 0; m_ctrl2 = 0; m_ctrl5 = 0; m_outz = 0; m_drdy = 0; m_lock = 0; m_pend = 0;
  endtask

  // at least one sample period has elapsed while sampling is enabled
  task automatic m_tick();
    if (m_ctrl2 != 0) begin
      if (m_lock) m_pend = 1;
      else begin m_outz = yaw_in; m_drdy = 1; end
    end
  endtask

  task automatic m_commit(input logic [15:0] f);
    if (f[15]) begin
      if (f[14:8] == 7'h27) begin m_lock = 1; m_drdy = 0; end
      else if (f[14:8] == 7'h26 && m_lock) begin
        m_lock = 0;
        if (m_pend) begin m_outz = yaw_in; m_drdy = 1; m_pend = 0; end
      end
    end else if (f[14:8] == 7'h0D) m_int1 = f[7:0];
    else if (f[14:8] == 7'h11) m_ctrl2 = f[7:0];
    else if (f[14:8] == 7'h14) m_ctrl5 = f[7:0];
  endtask

  always @(posedge SCLK) if (miso_chk && bit_i >= 8) check("miso_bit", MISO, exp_rx[15-bit_i]);
  always @(negedge clk) if (int_chk) check("int", INT, m_drdy & m_int1[1]);

  task automatic xfer(input logic [15:0] f, input int nbits, input int rst_at, output logic [7:0] got);
    logic aborted;
    aborted = 0;
    got = '0;
    exp_rx = m_read(f[14:8]);
    miso_chk = f[15] && nbits == 16 && rst_at < 0;
`ifdef INERT_SERF_NOISE_EN
    if (f[14:8] == 7'h26 || f[14:8] == 7'h27) miso_chk = 0;
`endif
    @(negedge clk); SS_n = 0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 0; MOSI = f[15-i];
      repeat (HALF) @(negedge clk);
      bit_i = i; SCLK = 1;
      if (i >= 8) got = {got[6:0], MISO};
      repeat (HALF) @(negedge clk);
      if (i == rst_at) begin
        rst_n = 0; #1;
        check("rst_miso", MISO, 0);
        check("rst_int", INT, 0);
        repeat (3) @(negedge clk);
        rst_n = 1; m_reset(); aborted = 1;
      end
    end
    miso_chk = 0; bit_i = -1;
    SS_n = 1; t_ss = cyc;
    repeat (HALF) @(negedge clk);
    if (!aborted) begin
      m_tick();
      if (nbits == 16) m_commit(f);
    end
  endtask

  task automatic quiet(input int n);
    repeat (100) @(negedge clk);
    m_tick();
    int_chk = 1;
    repeat (n) @(negedge clk);
    int_chk = 0;
  endtask

  initial begin
    logic [7:0] g, hi;
    int w, lat;
    m_reset();
    repeat (4) @(negedge clk);
    check("reset_miso", MISO, 0);
    check("reset_int", INT, 0);
    rst_n = 1;
    repeat (4) @(negedge clk);
    xfer(16'h0D02, 16, -1, g);
    xfer(16'h8F00, 16, -1, g); check("whoami", g, 8'h6A);
    xfer(16'h0F55, 16, -1, g);
    xfer(16'h8F00, 16, -1, g); check("whoami_ro", g, 8'h6A);
    xfer(16'h8000, 16, -1, g); check("unimpl_rd", g, 8'h00);
    xfer(16'h8D00, 16, -1, g); check("int1_rd", g, 8'h02);
    quiet(20); check("int_no_sampling", INT, 0);
    xfer(16'h1440, 16, -1, g);
    xfer(16'h9400, 16, -1, g); check("ctrl5_rd", g, 8'h40);
    yaw_in = 16'hFF38;
    xfer(16'h1160, 16, -1, g);
    w = 0;
    while (INT !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    lat = cyc - t_ss;
    check("int_rise_latency", lat >= 65 && lat <= 73, 1);
    m_tick();
    xfer(16'h9100, 16, -1, g); check("ctrl2_rd", g, 8'h60);
`ifndef INERT_SERF_NOISE_EN
    xfer(16'hA700, 16, -1, g); check("outz_h", g, 8'hFF);
    quiet(20); check("int_cleared", INT, 0);
    xfer(16'hA600, 16, -1, g); check("outz_l", g, 8'h38);
    quiet(20); check("int_reassert", INT, 1);
    xfer(16'hA700, 16, -1, g); check("lock_h", g, 8'hFF);
    yaw_in = 16'h0100;
    quiet(20);
    xfer(16'hA600, 16, -1, g); check("lock_old_l", g, 8'h38);
    quiet(20); check("int_after_unlock", INT, 1);
    xfer(16'hA700, 16, -1, g); check("new_h", g, 8'h01);
    xfer(16'hA600, 16, -1, g); check("new_l", g, 8'h00);
`else
    yaw_in = 16'h7FFF;
    for (int k = 0; k < 6; k++) begin
      quiet(5);
      xfer(16'hA700, 16, -1, hi);
      xfer(16'hA600, 16, -1, g);
      check("noise_range", {hi, g} >= 16'h7FF7 && {hi, g} <= 16'h7FFF, 1);
    end
`endif
    xfer(16'h0D00, 10, -1, g);
    xfer(16'h8D00, 16, -1, g); check("abort_int1", g, 8'h02);
    xfer(16'hA700, 16, -1, g);
    quiet(20); check("abort_int_low", INT, 0);
    xfer(16'hA600, 16, -1, g);
    quiet(20); check("abort_int_fires", INT, 1);
    xfer(16'h1477, 16, 12, g);
    xfer(16'h8D00, 16, -1, g); check("rst_int1", g, 8'h00);
    xfer(16'h9100, 16, -1, g); check("rst_ctrl2", g, 8'h00);
    xfer(16'h9400, 16, -1, g); check("rst_ctrl5", g, 8'h00);
    xfer(16'hA700, 16, -1, g); check("rst_outz_h", g, 8'h00);
    quiet(20); check("rst_int_idle", INT, 0);
    xfer(16'h0D02, 16, -1, g);
    xfer(16'h8D00, 16, -1, g); check("post_rst_frame", g, 8'h02);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
